// File: rtl/mcm_host_sequencer.sv
// rtl/mcm_host_sequencer.sv - drdy-handshake initiator for the masked multiplier
// One transaction in flight: accept operands, refresh randomness, pulse drdy_i, wait, return result.
module mcm_host_sequencer #(
   parameter int STATE_W = 128,
   parameter int RAND_W  = 160,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               seed_load,
   input  logic [31:0]        seed,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_p1,
   input  logic [STATE_W-1:0] in_p2,
   output logic               mul_drdy_i,
   output logic [STATE_W-1:0] mul_p1,
   output logic [STATE_W-1:0] mul_p2,
   output logic [RAND_W-1:0]  mul_random_vect,
   input  logic               mul_drdy_o,
   input  logic [STATE_W-1:0] mul_out,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [STATE_W-1:0] res_data,
   output logic               res_err
);

   localparam int NW  = RAND_W / 32;
   localparam int K_W = (NW > 1) ? $clog2(NW) : 1;
   localparam int C_W = $clog2(TIMEOUT + 1);
   localparam logic [31:0] POLY = 32'h8020_0003;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REFRESH,
      S_ISSUE,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t          state;
   logic [31:0]     lfsr;
   logic [K_W-1:0]  word_cnt;
   logic [C_W-1:0]  wait_cnt;

   // Galois right-shift form of x^32+x^22+x^2+x+1
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? POLY : 32'h0);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= S_IDLE;
         lfsr            <= 32'h1;
         word_cnt        <= '0;
         wait_cnt        <= '0;
         in_ready        <= 1'b1;
         mul_drdy_i      <= 1'b0;
         mul_p1          <= '0;
         mul_p2          <= '0;
         mul_random_vect <= '0;
         res_valid       <= 1'b0;
         res_data        <= '0;
         res_err         <= 1'b0;
      end else begin
         mul_drdy_i <= 1'b0;
         case (state)
            S_IDLE: begin
               if (seed_load)
                  lfsr <= (seed == '0) ? 32'h1 : seed;
               if (in_valid) begin
                  mul_p1   <= in_p1;
                  mul_p2   <= in_p2;
                  word_cnt <= '0;
                  in_ready <= 1'b0;
                  state    <= S_REFRESH;
               end
            end
            S_REFRESH: begin
               mul_random_vect[32*word_cnt +: 32] <= lfsr;
               lfsr     <= lfsr_step(lfsr);
               word_cnt <= word_cnt + 1'b1;
               if (word_cnt == K_W'(NW - 1)) begin
                  mul_drdy_i <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               // ISSUE plus TIMEOUT-1 WAIT cycles puts res_valid TIMEOUT cycles after drdy_i
               if (mul_drdy_o) begin
                  res_data  <= mul_out;
                  res_err   <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= S_HOLD;
               end else if (wait_cnt == C_W'(TIMEOUT - 2)) begin
                  res_data  <= '0;
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mcm_host_sequencer.sv
// tb/tb_mcm_host_sequencer.sv - directed bench for mcm_host_sequencer
// Vector table of whole transactions plus hand sequences for hold, reset and stray strobes.
module tb_mcm_host_sequencer;

   logic         clk;
   logic         rst;
   logic         seed_load;
   logic [31:0]  seed;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_p1, in_p2;
   logic         mul_drdy_i;
   logic [127:0] mul_p1, mul_p2;
   logic [159:0] mul_random_vect;
   logic         mul_drdy_o;
   logic [127:0] mul_out;
   logic         res_valid;
   logic         res_ready;
   logic [127:0] res_data;
   logic         res_err;

   mcm_host_sequencer #(.STATE_W(128), .RAND_W(160), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
      .in_valid(in_valid), .in_ready(in_ready), .in_p1(in_p1), .in_p2(in_p2),
      .mul_drdy_i(mul_drdy_i), .mul_p1(mul_p1), .mul_p2(mul_p2),
      .mul_random_vect(mul_random_vect), .mul_drdy_o(mul_drdy_o), .mul_out(mul_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int drdy_cnt = 0;
   int drdy_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mul_drdy_i) begin
         drdy_cnt <= drdy_cnt + 1;
         drdy_cyc <= cyc;
      end
   end

   // Multiplier model: strobes mdl_lat cycles after drdy_i; mdl_lat==0 never answers
   int           mdl_lat = 0;
   logic [127:0] mdl_data = '0;
   int           mdl_cd = 0;
   logic         mdl_strobe = 1'b0;
   logic         man_strobe;
   logic [127:0] man_data;

   always @(negedge clk) begin
      if (mdl_lat > 0 && mul_drdy_i) mdl_cd <= mdl_lat;
      else if (mdl_cd > 0) mdl_cd <= mdl_cd - 1;
      mdl_strobe <= (mdl_cd == 1);
   end

   assign mul_drdy_o = mdl_strobe | man_strobe;
   assign mul_out    = mdl_strobe ? mdl_data : man_data;

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic         ld;
      logic [31:0]  seed;
      logic [127:0] p1;
      logic [127:0] p2;
      int           lat;
      logic [127:0] mres;
      int           rv_off;
      logic [127:0] edata;
      logic         eerr;
      logic         cv;
      logic [159:0] evect;
   } vec_t;

   vec_t         vt[5];
   logic [159:0] rec_vect[5];
   localparam logic [159:0] V0 = {32'hB02C0003, 32'h60180001, 32'hC0300002, 32'h80200003, 32'h00000001};
   localparam logic [159:0] V1 = {32'h6D9B6001, 32'hDB36C002, 32'hB62D8003, 32'h6C1B0001, 32'hD8360002};

   task automatic start_txn(input logic ld, input logic [31:0] sd, input logic [127:0] p1,
                            input logic [127:0] p2, input int lat, input logic [127:0] mres,
                            output int c0, output int base);
      @(posedge clk); #1;
      seed_load = ld; seed = sd; in_valid = 1'b1; in_p1 = p1; in_p2 = p2;
      mdl_lat = lat; mdl_data = mres;
      c0 = cyc; base = drdy_cnt;
      @(negedge clk);
      check("in_ready_idle", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; seed_load = 1'b0;
      @(negedge clk);
      check("in_ready_busy", in_ready, 1'b0);
   endtask

   task automatic wait_result(output logic got);
      got = 1'b0;
      for (int n = 0; n < 200 && !got; n++) begin
         if (res_valid) got = 1'b1;
         else @(negedge clk);
      end
      check("res_valid_seen", got, 1'b1);
   endtask

   task automatic handshake;
      @(posedge clk); #1 res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
      @(negedge clk);
      check("res_valid_drop", res_valid, 1'b0);
      check("in_ready_back", in_ready, 1'b1);
   endtask

   task automatic run_vec(input vec_t v, output logic [159:0] vect);
      int c0, base;
      logic got;
      start_txn(v.ld, v.seed, v.p1, v.p2, v.lat, v.mres, c0, base);
      wait_result(got);
      check("res_valid_latency", cyc - c0, v.rv_off);
      check("drdy_latency", drdy_cyc - c0, 6);
      check("drdy_pulses", drdy_cnt - base, 1);
      check("res_data", res_data, v.edata);
      check("res_err", res_err, v.eerr);
      check("mul_p1", mul_p1, v.p1);
      check("mul_p2", mul_p2, v.p2);
      if (v.cv) check("random_vect", mul_random_vect, v.evect);
      vect = mul_random_vect;
      handshake();
   endtask

   initial begin
      int c0, base, bad_rdy, bad_data, bad_valid, dups;
      logic got;
      logic [31:0] w[10];
      vec_t v;

      vt[0] = '{1'b1, 32'h1,    128'h1, 128'h2, 3,  128'hABCD, 10, 128'hABCD, 1'b0, 1'b1, V0};
      vt[1] = '{1'b0, 32'h0,    128'h3, 128'h4, 1,  128'h1234, 8,  128'h1234, 1'b0, 1'b1, V1};
      vt[2] = '{1'b0, 32'h0,    128'h5, 128'h6, 0,  128'hDEAD, 70, 128'h0,    1'b1, 1'b0, '0};
      vt[3] = '{1'b1, 32'h0,    128'h7, 128'h8, 5,  128'hCAFE, 12, 128'hCAFE, 1'b0, 1'b1, V0};
      vt[4] = '{1'b1, 32'h1234, 128'h9, 128'hA, 63, 128'h5555, 70, 128'h5555, 1'b0, 1'b0, '0};

      rst = 1'b0; seed_load = 1'b0; seed = '0; in_valid = 1'b0; in_p1 = '0; in_p2 = '0;
      res_ready = 1'b0; man_strobe = 1'b0; man_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_drdy_i", mul_drdy_i, 1'b0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_err", res_err, 1'b0);
      check("rst_res_data", res_data, 128'h0);
      check("rst_vect", mul_random_vect, 160'h0);
      @(posedge clk); #1 rst = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(vt[i], rec_vect[i]);

      for (int i = 0; i < 5; i++) begin
         w[i]     = rec_vect[0][32*i +: 32];
         w[i + 5] = rec_vect[1][32*i +: 32];
      end
      dups = 0;
      for (int i = 0; i < 10; i++)
         for (int j = i + 1; j < 10; j++)
            if (w[i] == w[j]) dups++;
      check("no_repeat_words", dups, 0);

      // Result held while downstream stalls; inputs and strobes must be ignored
      start_txn(1'b0, 32'h0, 128'h11, 128'h22, 2, 128'h77, c0, base);
      wait_result(got);
      bad_rdy = 0; bad_data = 0; bad_valid = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; man_strobe = n[0]; man_data = 128'hF000 + 128'(n);
         @(negedge clk);
         if (in_ready !== 1'b0) bad_rdy++;
         if (res_data !== 128'h77) bad_data++;
         if (res_valid !== 1'b1) bad_valid++;
      end
      @(posedge clk); #1 in_valid = 1'b0; man_strobe = 1'b0;
      check("hold_in_ready", bad_rdy, 0);
      check("hold_res_data", bad_data, 0);
      check("hold_res_valid", bad_valid, 0);
      check("hold_drdy_pulses", drdy_cnt - base, 1);
      handshake();

      // Reset in WAIT, then a stray strobe
      start_txn(1'b0, 32'h0, 128'h33, 128'h44, 0, 128'h0, c0, base);
      repeat (8) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("mid_rst_in_ready", in_ready, 1'b1);
      check("mid_rst_res_valid", res_valid, 1'b0);
      check("mid_rst_res_data", res_data, 128'h0);
      check("mid_rst_mul_p1", mul_p1, 128'h0);
      check("mid_rst_vect", mul_random_vect, 160'h0);
      @(posedge clk); #1 man_strobe = 1'b1; man_data = 128'hFFFF;
      @(posedge clk); #1 man_strobe = 1'b0;
      @(negedge clk);
      check("stray_in_ready", in_ready, 1'b1);
      check("stray_res_valid", res_valid, 1'b0);
      check("stray_res_data", res_data, 128'h0);
      v = vt[0];
      v.ld = 1'b0;
      run_vec(v, rec_vect[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
